// File: rtl/beam_pkg.sv
// Shared definitions for the 4-block beam transmitter: lane geometry,
// default-width lane typedefs, read-pipe depth split and the FSM state enum.
package beam_pkg;

  localparam int BEAM_LANES = 64;
  localparam int BLK_LANES  = 16;
  localparam int NUM_BLKS   = 4;
  localparam int BEAM_DW    = 40;

  // The RAM contributes two registered stages; the lane mux adds the third.
  localparam int RAM_LAT    = 2;

  typedef logic [BEAM_LANES-1:0][BEAM_DW-1:0] beam_beat_t;
  typedef logic [BLK_LANES-1:0][BEAM_DW-1:0]  blk_beat_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_GAP   = 2'd3
  } beam_state_e;

endpackage

// File: rtl/beam_unbuf_ram.sv
// Simple dual-port frame RAM: one 64-lane beat per address, synchronous write,
// registered read with RAM_LAT stages. Contents are never cleared.
module beam_unbuf_ram
  import beam_pkg::*;
#(
  parameter int DATA_WIDTH = 40,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                                   i_clk,
  input  logic                                   i_we,
  input  logic [ADDR_WIDTH-1:0]                  i_waddr,
  input  logic [BEAM_LANES-1:0][DATA_WIDTH-1:0]  i_wdata,
  input  logic                                   i_re,
  input  logic [ADDR_WIDTH-1:0]                  i_raddr,
  output logic [BEAM_LANES-1:0][DATA_WIDTH-1:0]  o_rdata
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [BEAM_LANES-1:0][DATA_WIDTH-1:0] mem [DEPTH];
  logic [BEAM_LANES-1:0][DATA_WIDTH-1:0] rdata_p0;
  logic [BEAM_LANES-1:0][DATA_WIDTH-1:0] rdata_p1;

  // Write port
  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  // Read port: stage p0 array read, stage p1 output register
  always_ff @(posedge i_clk) begin
    if (i_re) rdata_p0 <= mem[i_raddr];
    rdata_p1 <= rdata_p0;
  end

  assign o_rdata = rdata_p1;

endmodule

// File: rtl/beam_unbuffer.sv
// Frame-level 64-lane to 4x16-lane burst transmitter. Captures a frame into
// RAM, then replays it four times, one 16-lane block per burst, with
// GAP_CYCLES idle cycles after every burst.
// Optional feature: define BEAM_UNBUF_DROP_CNT_EN to count beats offered
// while o_ready is low; otherwise o_drop_cnt is tied to zero.
module beam_unbuffer
  import beam_pkg::*;
#(
  parameter int DATA_WIDTH = 40,
  parameter int ADDR_WIDTH = 11,
  parameter int GAP_CYCLES = 4,
  parameter int RD_LAT     = 3
) (
  input  logic                                   i_clk,
  input  logic                                   i_reset_n,
  input  logic                                   i_vld,
  input  logic                                   i_last,
  input  logic [BEAM_LANES-1:0][DATA_WIDTH-1:0]  i_data,
  output logic                                   o_ready,
  output logic [BLK_LANES-1:0][DATA_WIDTH-1:0]   o_data,
  output logic                                   o_tvalid,
  output logic                                   o_tlast,
  output logic [1:0]                             o_blk_idx,
  output logic [ADDR_WIDTH-1:0]                  o_rd_addr,
  output logic                                   o_ovf,
  output logic [15:0]                            o_drop_cnt
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  // A shorter gap would let a new frame overwrite addresses still in the read pipe.
  if (GAP_CYCLES < RD_LAT || RD_LAT != RAM_LAT + 1) begin : g_param_chk
    $error("beam_unbuffer: GAP_CYCLES must be >= RD_LAT and RD_LAT must be RAM_LAT+1");
  end

  beam_state_e             state, state_nxt;
  logic [ADDR_WIDTH-1:0]   wr_addr, wr_ptr, rd_cnt;
  logic [ADDR_WIDTH:0]     len;
  logic [1:0]              blk;
  logic [GAP_W-1:0]        gap_cnt;
  logic                    wr_en, rd_en, wr_full, rd_last, gap_done;

  logic [BEAM_LANES-1:0][DATA_WIDTH-1:0] ram_rdata;

  assign wr_full  = (wr_addr == ADDR_WIDTH'(DEPTH - 1));
  assign rd_last  = ({1'b0, rd_cnt} == len - 1'b1);
  assign gap_done = (gap_cnt == GAP_W'(GAP_CYCLES - 1));

  // State register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (i_vld)           state_nxt = i_last ? ST_DRAIN : ST_FILL;
      ST_FILL:  if (i_vld && i_last) state_nxt = ST_DRAIN;
      ST_DRAIN: if (rd_last)         state_nxt = ST_GAP;
      ST_GAP:   if (gap_done)        state_nxt = (blk == 2'(NUM_BLKS - 1)) ? ST_IDLE : ST_DRAIN;
      default:                       state_nxt = ST_IDLE;
    endcase
  end

  // State outputs: handshake, RAM write and read strobes
  always_comb begin
    o_ready = 1'b0;
    wr_en   = 1'b0;
    wr_ptr  = wr_addr + 1'b1;
    rd_en   = 1'b0;
    case (state)
      ST_IDLE: begin
        o_ready = 1'b1;
        wr_en   = i_vld;
        wr_ptr  = '0;
      end
      ST_FILL: begin
        o_ready = 1'b1;
        wr_en   = i_vld & ~wr_full;
      end
      ST_DRAIN: rd_en = 1'b1;
      default: ;
    endcase
  end

  // Frame counters: write pointer, frame length, read pointer, block and gap timer, overflow
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_addr <= '0;
      len     <= '0;
      rd_cnt  <= '0;
      blk     <= '0;
      gap_cnt <= '0;
      o_ovf   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (i_vld) begin
          wr_addr <= '0;
          len     <= (ADDR_WIDTH+1)'(1);
          rd_cnt  <= '0;
          blk     <= '0;
          o_ovf   <= 1'b0;
        end
        ST_FILL: if (i_vld) begin
          if (!wr_full)     wr_addr <= wr_addr + 1'b1;
          else if (!i_last) o_ovf   <= 1'b1;
          if (i_last) len <= wr_full ? (ADDR_WIDTH+1)'(DEPTH)
                                     : {1'b0, wr_addr} + (ADDR_WIDTH+1)'(2);
        end
        ST_DRAIN: begin
          if (!rd_last) rd_cnt <= rd_cnt + 1'b1;
          gap_cnt <= '0;
        end
        ST_GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_done) begin
            rd_cnt <= '0;
            blk    <= blk + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  beam_unbuf_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (wr_en),
    .i_waddr (wr_ptr),
    .i_wdata (i_data),
    .i_re    (rd_en),
    .i_raddr (rd_cnt),
    .o_rdata (ram_rdata)
  );

  logic                  vld_p0, vld_p1, vld_p2;
  logic                  last_p0, last_p1, last_p2;
  logic [1:0]            blk_p0, blk_p1, blk_p2;
  logic [ADDR_WIDTH-1:0] addr_p0, addr_p1, addr_p2;
  logic [BLK_LANES-1:0][DATA_WIDTH-1:0] data_p2;

  // Sideband pipe tracking each read alongside the RAM stages
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      vld_p0  <= 1'b0; vld_p1  <= 1'b0; vld_p2  <= 1'b0;
      last_p0 <= 1'b0; last_p1 <= 1'b0; last_p2 <= 1'b0;
      blk_p0  <= '0;   blk_p1  <= '0;   blk_p2  <= '0;
      addr_p0 <= '0;   addr_p1 <= '0;   addr_p2 <= '0;
    end else begin
      // Stage p0: read issued
      vld_p0  <= rd_en;
      last_p0 <= rd_en & rd_last;
      blk_p0  <= blk;
      addr_p0 <= rd_cnt;
      // Stage p1: aligned with RAM output
      vld_p1  <= vld_p0;
      last_p1 <= last_p0;
      blk_p1  <= blk_p0;
      addr_p1 <= addr_p0;
      // Stage p2: aligned with lane-mux register
      vld_p2  <= vld_p1;
      last_p2 <= last_p1;
      blk_p2  <= blk_p1;
      addr_p2 <= addr_p1;
    end
  end

  // Lane mux: pick the 16 lanes of the current block out of the 64-lane beat
  always_ff @(posedge i_clk) begin
    data_p2 <= ram_rdata[{blk_p1, 4'b0000} +: BLK_LANES];
  end

  // Data is held at zero outside bursts so reset forces it low without resetting the data path.
  assign o_data    = vld_p2 ? data_p2 : '0;
  assign o_tvalid  = vld_p2;
  assign o_tlast   = last_p2;
  assign o_blk_idx = blk_p2;
  assign o_rd_addr = addr_p2;

`ifdef BEAM_UNBUF_DROP_CNT_EN
  logic [15:0] drop_cnt;

  // Saturating count of beats offered while not ready
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                                        drop_cnt <= '0;
    else if (i_vld && !o_ready && drop_cnt != 16'hFFFF)    drop_cnt <= drop_cnt + 1'b1;
  end

  assign o_drop_cnt = drop_cnt;
`else
  assign o_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_beam_unbuffer.sv
// Self-checking bench for beam_unbuffer (small 8-deep configuration).
module tb_beam_unbuffer;
  import beam_pkg::*;

  localparam int DW    = 40;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int GAP   = 4;

  typedef logic [BLK_LANES-1:0][DW-1:0] blk_t;

  typedef struct {
    blk_t          data;
    logic          last;
    logic [1:0]    blk;
    logic [AW-1:0] addr;
  } exp_t;

  typedef struct {
    int nbeats;
    bit hold;
    bit exp_ovf;
  } vec_t;

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic                          i_vld, i_last;
  logic [BEAM_LANES-1:0][DW-1:0] i_data;
  logic                          o_ready, o_tvalid, o_tlast, o_ovf;
  blk_t                          o_data;
  logic [1:0]                    o_blk_idx;
  logic [AW-1:0]                 o_rd_addr;
  logic [15:0]                   o_drop_cnt;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;
  bit   mon_en = 1'b0;
  bit   prev_tv = 1'b0;
  int   low_cnt = 0;
  int   exp_drops = 0;

  beam_unbuffer #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .GAP_CYCLES (GAP),
    .RD_LAT     (3)
  ) dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_vld      (i_vld),
    .i_last     (i_last),
    .i_data     (i_data),
    .o_ready    (o_ready),
    .o_data     (o_data),
    .o_tvalid   (o_tvalid),
    .o_tlast    (o_tlast),
    .o_blk_idx  (o_blk_idx),
    .o_rd_addr  (o_rd_addr),
    .o_ovf      (o_ovf),
    .o_drop_cnt (o_drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] samp(int fid, int a, int l);
    return {8'(fid), 16'(a), 16'(l)};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_data(string name, blk_t act, blk_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected replay: four bursts, block k carries lanes 16k..16k+15 of every stored beat
  task automatic push_exp(int fid, int n);
    exp_t e;
    int   len;
    len = (n > DEPTH) ? DEPTH : n;
    for (int k = 0; k < NUM_BLKS; k++) begin
      for (int a = 0; a < len; a++) begin
        for (int j = 0; j < BLK_LANES; j++) e.data[j] = samp(fid, a, BLK_LANES*k + j);
        e.last = (a == len - 1);
        e.blk  = 2'(k);
        e.addr = AW'(a);
        sb.push_back(e);
      end
    end
  endtask

  task automatic drive_beat(int fid, int a, bit last);
    i_vld  = 1'b1;
    i_last = last;
    for (int l = 0; l < BEAM_LANES; l++) i_data[l] = samp(fid, a, l);
    tick();
    i_vld  = 1'b0;
    i_last = 1'b0;
  endtask

  task automatic send_frame(int fid, int n);
    int w;
    w = 0;
    while (!o_ready && w < 500) begin tick(); w++; end
    check("ready_before_frame", {63'd0, o_ready}, 64'd1);
    for (int a = 0; a < n; a++) drive_beat(fid, a, a == n - 1);
  endtask

  task automatic wait_done();
    int w;
    w = 0;
    while ((sb.size() != 0 || !o_ready) && w < 2000) begin tick(); w++; end
    checks++;
    if (sb.size() != 0 || !o_ready) begin
      errors++;
      $display("FAIL drain_timeout actual pending=%0d ready=%0b required pending=0 ready=1",
               sb.size(), o_ready);
      sb.delete();
    end
  endtask

  // Output monitor: pops the scoreboard on every valid beat and checks inter-burst gaps
  always @(negedge clk) begin
    if (!mon_en) begin
      prev_tv = 1'b0;
      low_cnt = 0;
    end else begin
      if (o_tvalid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat actual blk=%0d addr=%0d required none", o_blk_idx, o_rd_addr);
        end else begin
          mon_e = sb.pop_front();
          check_data("o_data", o_data, mon_e.data);
          check("o_tlast", {63'd0, o_tlast}, {63'd0, mon_e.last});
          check("o_blk_idx", {62'd0, o_blk_idx}, {62'd0, mon_e.blk});
          check("o_rd_addr", {61'd0, o_rd_addr}, {61'd0, mon_e.addr});
          if (!prev_tv && mon_e.blk != 2'd0 && mon_e.addr == '0)
            check("gap_len", 64'(low_cnt), 64'(GAP));
        end
        low_cnt = 0;
      end else begin
        low_cnt++;
      end
      prev_tv = o_tvalid;
    end
  end

  task automatic check_reset_outputs(string tag);
    check({tag, "_tvalid"}, {63'd0, o_tvalid}, 64'd0);
    check({tag, "_tlast"},  {63'd0, o_tlast},  64'd0);
    check_data({tag, "_data"}, o_data, '0);
    check({tag, "_blk"},    {62'd0, o_blk_idx}, 64'd0);
    check({tag, "_addr"},   {61'd0, o_rd_addr}, 64'd0);
    check({tag, "_ready"},  {63'd0, o_ready},  64'd1);
    check({tag, "_ovf"},    {63'd0, o_ovf},    64'd0);
    check({tag, "_drop"},   {48'd0, o_drop_cnt}, 64'd0);
  endtask

  initial begin
    vec_t vecs[6];
    int   w, len, hold_n;

    vecs[0] = '{nbeats: 8,  hold: 1'b0, exp_ovf: 1'b0};
    vecs[1] = '{nbeats: 1,  hold: 1'b0, exp_ovf: 1'b0};
    vecs[2] = '{nbeats: 10, hold: 1'b0, exp_ovf: 1'b1};
    vecs[3] = '{nbeats: 4,  hold: 1'b1, exp_ovf: 1'b0};
    vecs[4] = '{nbeats: 3,  hold: 1'b0, exp_ovf: 1'b0};
    vecs[5] = '{nbeats: 2,  hold: 1'b1, exp_ovf: 1'b0};

    rst_n  = 1'b0;
    i_vld  = 1'b0;
    i_last = 1'b0;
    i_data = '0;
    #3;
    check_reset_outputs("reset");
    tick(); tick();
    rst_n  = 1'b1;
    mon_en = 1'b1;
    tick();

    for (int v = 0; v < 6; v++) begin
      len = (vecs[v].nbeats > DEPTH) ? DEPTH : vecs[v].nbeats;
      send_frame(v + 1, vecs[v].nbeats);
      push_exp(v + 1, vecs[v].nbeats);
      check("ready_low_drain", {63'd0, o_ready}, 64'd0);
      check("ovf_after_frame", {63'd0, o_ovf}, {63'd0, vecs[v].exp_ovf});
      if (vecs[v].hold) begin
        // Offer junk beats for most of the replay; none may reach the RAM.
        hold_n = NUM_BLKS*len + GAP;
        i_vld  = 1'b1;
        for (int l = 0; l < BEAM_LANES; l++) i_data[l] = samp(8'hEE, 99, l);
        repeat (hold_n) tick();
        i_vld  = 1'b0;
`ifdef BEAM_UNBUF_DROP_CNT_EN
        exp_drops += hold_n;
`endif
      end
      wait_done();
      check("ready_after_replay", {63'd0, o_ready}, 64'd1);
      check("ovf_sticky", {63'd0, o_ovf}, {63'd0, vecs[v].exp_ovf});
      check("drop_cnt", {48'd0, o_drop_cnt}, 64'(exp_drops));
    end

    // Overflowed frame, then the first beat of the next frame clears the flag
    send_frame(30, 12);
    push_exp(30, 12);
    wait_done();
    check("ovf_set_12", {63'd0, o_ovf}, 64'd1);
    drive_beat(31, 0, 1'b0);
    check("ovf_clear_first_beat", {63'd0, o_ovf}, 64'd0);
    drive_beat(31, 1, 1'b1);
    push_exp(31, 2);
    wait_done();

    // Reset pulsed during the third burst: outputs drop at once, partial replay never resumes
    send_frame(40, 4);
    push_exp(40, 4);
    w = 0;
    while (!(o_tvalid && o_blk_idx == 2'd2) && w < 500) begin tick(); w++; end
    check("reach_blk2", {63'd0, (o_tvalid && o_blk_idx == 2'd2)}, 64'd1);
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_reset_outputs("midreset");
    sb.delete();
    exp_drops = 0;
    tick(); tick();
    rst_n  = 1'b1;
    mon_en = 1'b1;
    tick();
    send_frame(41, 4);
    push_exp(41, 4);
    wait_done();
    check("ovf_after_reset_frame", {63'd0, o_ovf}, 64'd0);
    repeat (10) tick();
    check("idle_no_stray", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
